cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the out-of-order core. It buffers finish results from the reservation-station ALU path and from the load/store buffer, then grants exactly one broadcast per cycle onto the single CDB. The CDB feeds the reorder buffer's finish port and the wake-up logic of both issue queues. Per-source skid FIFOs absorb collisions, round-robin arbitration prevents starvation, and a branch-mispredict flush clears all in-flight results.

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_fifo.sv | 68 ++++++
 rtl/cdb_arbiter.sv | 139 +++++++++++++
 tb/tb_cdb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: default RoB id width
// and the CDB source encoding.
package cdb_arbiter_pkg;

  // Default width of a reorder-buffer entry id
  localparam int CDB_ROB_BITS  = 4;
  // Width of a broadcast result value
  localparam int CDB_DATA_BITS = 32;

  // Which source owns the bus this cycle
  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  // The source that did not win last time gets priority on a collision
  function automatic cdb_src_e cdbOtherSrc(input cdb_src_e src);
    return (src == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Skid FIFO holding finished results for one CDB source. Ready depends only
// on the registered count, so a same-cycle pop never frees a slot for a push.
module cdb_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ready_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pushOk, popOk;

  assign ready_o = (count_q != CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];
  assign pushOk  = push_i && ready_o && !flush_i;
  assign popOk   = pop_i && (count_q != '0) && !flush_i;

  // Next pointers and occupancy; flush returns everything to empty
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushOk) wrPtr_d = wrPtr_q + PW'(1);
      if (popOk)  rdPtr_d = rdPtr_q + PW'(1);
      if (pushOk && !popOk)      count_d = count_q + CW'(1);
      else if (popOk && !pushOk) count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the count
  always_ff @(posedge clk_in) begin
    if (pushOk) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers ALU and LSB results in skid FIFOs and
// grants one broadcast per cycle with round-robin priority.
// Optional feature macro CDB_BYPASS_EN: an empty FIFO's offered input may be
// broadcast in the same cycle instead of going through the FIFO.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_BITS   = CDB_ROB_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush,
  input  logic                alu_valid,
  input  logic [ROB_BITS-1:0] alu_rob_id,
  input  logic [31:0]         alu_value,
  output logic                alu_ready,
  input  logic                lsb_valid,
  input  logic [ROB_BITS-1:0] lsb_rob_id,
  input  logic [31:0]         lsb_value,
  output logic                lsb_ready,
  output logic                cdb_valid,
  output logic [ROB_BITS-1:0] cdb_rob_id,
  output logic [31:0]         cdb_value,
  output logic                cdb_src
);

  localparam int ENTRY_W = ROB_BITS + CDB_DATA_BITS;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  logic [ENTRY_W-1:0] aluHead, lsbHead;
  logic [CW-1:0]      aluCount, lsbCount;
  logic               aluEmpty, lsbEmpty;
  logic               aluCand, lsbCand;
  logic               aluPush, lsbPush, aluPop, lsbPop;
  logic               aluBypass, lsbBypass;
  logic               active;
  cdb_src_e           grant;
  cdb_src_e           lastGrant_q, lastGrant_d;

  assign active   = rdy_in && !flush;
  assign aluEmpty = (aluCount == '0);
  assign lsbEmpty = (lsbCount == '0);

  // A source competes when it has something buffered, or when bypass allows its live offer
  always_comb begin
`ifdef CDB_BYPASS_EN
    aluCand = !aluEmpty || alu_valid;
    lsbCand = !lsbEmpty || lsb_valid;
`else
    aluCand = !aluEmpty;
    lsbCand = !lsbEmpty;
`endif
  end

  // Round-robin grant and the bus mux from FIFO head or bypassed input
  always_comb begin
    grant      = CDB_SRC_ALU;
    cdb_valid  = 1'b0;
    cdb_rob_id = '0;
    cdb_value  = '0;
    cdb_src    = 1'b0;
    aluPop     = 1'b0;
    lsbPop     = 1'b0;
    aluBypass  = 1'b0;
    lsbBypass  = 1'b0;
    if (active && (aluCand || lsbCand)) begin
      if (aluCand && lsbCand) grant = cdbOtherSrc(lastGrant_q);
      else if (lsbCand)       grant = CDB_SRC_LSB;
      else                    grant = CDB_SRC_ALU;
      cdb_valid = 1'b1;
      cdb_src   = grant;
      if (grant == CDB_SRC_ALU) begin
        if (aluEmpty) begin
          aluBypass  = 1'b1;
          cdb_rob_id = alu_rob_id;
          cdb_value  = alu_value;
        end else begin
          aluPop                  = 1'b1;
          {cdb_rob_id, cdb_value} = aluHead;
        end
      end else begin
        if (lsbEmpty) begin
          lsbBypass  = 1'b1;
          cdb_rob_id = lsb_rob_id;
          cdb_value  = lsb_value;
        end else begin
          lsbPop                  = 1'b1;
          {cdb_rob_id, cdb_value} = lsbHead;
        end
      end
    end
  end

  // An offer is enqueued unless it was consumed straight onto the bus
  always_comb begin
    aluPush = alu_valid && active && !aluBypass;
    lsbPush = lsb_valid && active && !lsbBypass;
  end

  // Remember the winner; a flush hands the next collision to the ALU
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (flush)          lastGrant_d = CDB_SRC_LSB;
    else if (cdb_valid) lastGrant_d = grant;
  end

  // Last-grant register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) lastGrant_q <= CDB_SRC_LSB;
    else        lastGrant_q <= lastGrant_d;
  end

  cdb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) aluFifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (aluPush),
    .pop_i   (aluPop),
    .flush_i (flush),
    .data_i  ({alu_rob_id, alu_value}),
    .head_o  (aluHead),
    .count_o (aluCount),
    .ready_o (alu_ready)
  );

  cdb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) lsbFifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (lsbPush),
    .pop_i   (lsbPop),
    .flush_i (flush),
    .data_i  ({lsb_rob_id, lsb_value}),
    .head_o  (lsbHead),
    .count_o (lsbCount),
    .ready_o (lsb_ready)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based model.
module tb_cdb_arbiter;

  localparam int DEPTH = 4;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in, flush;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_rob_id, lsb_rob_id;
  logic [31:0] alu_value, lsb_value;
  logic        alu_ready, lsb_ready;
  logic        cdb_valid, cdb_src;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue of {id,value} per source plus who won last
  logic [35:0] aq[$];
  logic [35:0] lq[$];
  bit          mLast;

  typedef struct {
    logic        av;  logic [3:0] aid; logic [31:0] aval;
    logic        lv;  logic [3:0] lid; logic [31:0] lval;
    logic        rdy; logic       fl;
    logic        ev;  logic [3:0] eid; logic [31:0] evalue;
    logic        esrc; logic      ear; logic        elr;
  } vec_t;

  vec_t vecs[10];

  cdb_arbiter #(.ROB_BITS(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush      (flush),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_ready  (alu_ready),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_ready  (lsb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  // One comparison, counted, reporting on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic av, input logic [3:0] aid, input logic [31:0] aval,
                             input logic lv, input logic [3:0] lid, input logic [31:0] lval,
                             input logic rdy, input logic fl);
    alu_valid = av; alu_rob_id = aid; alu_value = aval;
    lsb_valid = lv; lsb_rob_id = lid; lsb_value = lval;
    rdy_in = rdy; flush = fl;
  endtask

  task automatic modelReset();
    aq.delete();
    lq.delete();
    mLast = 1'b1;
  endtask

  // Drive one cycle, compare against the model, then advance model and clock
  task automatic applyStimulus(input string tag,
                               input logic av, input logic [3:0] aid, input logic [31:0] aval,
                               input logic lv, input logic [3:0] lid, input logic [31:0] lval,
                               input logic rdy, input logic fl);
    bit aHas, lHas, aCand, lCand, eValid, pick, aAcc, lAcc;
    logic [3:0]  eId;
    logic [31:0] eVal;
    driveInputs(av, aid, aval, lv, lid, lval, rdy, fl);
    #1;
    aHas  = aq.size() > 0;
    lHas  = lq.size() > 0;
    aCand = aHas || (BYP && av);
    lCand = lHas || (BYP && lv);
    eValid = 1'b0; pick = 1'b0; eId = '0; eVal = '0;
    if (rdy && !fl && (aCand || lCand)) begin
      eValid = 1'b1;
      if (aCand && lCand) pick = !mLast;
      else                pick = lCand;
      if (!pick) {eId, eVal} = aHas ? aq[0] : {aid, aval};
      else       {eId, eVal} = lHas ? lq[0] : {lid, lval};
    end
    checkOutput({tag, ".valid"},    cdb_valid,  eValid);
    checkOutput({tag, ".id"},       cdb_rob_id, eId);
    checkOutput({tag, ".value"},    cdb_value,  eVal);
    checkOutput({tag, ".src"},      cdb_src,    pick);
    checkOutput({tag, ".aluReady"}, alu_ready,  aq.size() != DEPTH);
    checkOutput({tag, ".lsbReady"}, lsb_ready,  lq.size() != DEPTH);
    aAcc = av && (aq.size() < DEPTH);
    lAcc = lv && (lq.size() < DEPTH);
    if (fl) begin
      modelReset();
    end else if (rdy) begin
      if (eValid) begin
        if (!pick) begin
          if (aHas) void'(aq.pop_front());
          else      aAcc = 1'b0;
        end else begin
          if (lHas) void'(lq.pop_front());
          else      lAcc = 1'b0;
        end
        mLast = pick;
      end
      if (aAcc) aq.push_back({aid, aval});
      if (lAcc) lq.push_back({lid, lval});
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Reset with offers present: nothing may broadcast and both FIFOs are ready
  task automatic doReset(input string tag);
    @(negedge clk_in);
    rst_in = 1'b1;
    driveInputs(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66, 1'b1, 1'b0);
    #1;
    checkOutput({tag, ".rstValid"},    cdb_valid,  1'b0);
    checkOutput({tag, ".rstId"},       cdb_rob_id, 4'd0);
    checkOutput({tag, ".rstValue"},    cdb_value,  32'd0);
    checkOutput({tag, ".rstSrc"},      cdb_src,    1'b0);
    checkOutput({tag, ".rstAluReady"}, alu_ready,  1'b1);
    checkOutput({tag, ".rstLsbReady"}, lsb_ready,  1'b1);
    @(negedge clk_in);
    rst_in = 1'b0;
    driveInputs(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    modelReset();
  endtask

  initial begin
    bit sawLsbFull;
    int aN, lN, guard;
    bit aAccept, lAccept;

    vecs[0] = '{0, 0, 0,     0, 0, 0,     1, 0, 0, 0, 0,     0, 1, 1};
    vecs[1] = '{1, 3, 'h11,  0, 0, 0,     1, 0, 0, 0, 0,     0, 1, 1};
    vecs[2] = '{0, 0, 0,     0, 0, 0,     1, 0, 1, 3, 'h11,  0, 1, 1};
    vecs[3] = '{0, 0, 0,     0, 0, 0,     1, 1, 0, 0, 0,     0, 1, 1};
    vecs[4] = '{1, 1, 'h101, 1, 2, 'h202, 1, 0, 0, 0, 0,     0, 1, 1};
    vecs[5] = '{0, 0, 0,     0, 0, 0,     1, 0, 1, 1, 'h101, 0, 1, 1};
    vecs[6] = '{0, 0, 0,     0, 0, 0,     1, 0, 1, 2, 'h202, 1, 1, 1};
    vecs[7] = '{0, 0, 0,     0, 0, 0,     1, 0, 0, 0, 0,     0, 1, 1};
    vecs[8] = '{1, 9, 'h99,  0, 0, 0,     0, 0, 0, 0, 0,     0, 1, 1};
    vecs[9] = '{0, 0, 0,     0, 0, 0,     1, 0, 0, 0, 0,     0, 1, 1};

    rst_in = 1'b1;
    driveInputs(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    doReset("boot");

`ifndef CDB_BYPASS_EN
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      driveInputs(vecs[i].av, vecs[i].aid, vecs[i].aval, vecs[i].lv, vecs[i].lid, vecs[i].lval,
                  vecs[i].rdy, vecs[i].fl);
      #1;
      checkOutput({tag, ".valid"},    cdb_valid,  vecs[i].ev);
      checkOutput({tag, ".id"},       cdb_rob_id, vecs[i].eid);
      checkOutput({tag, ".value"},    cdb_value,  vecs[i].evalue);
      checkOutput({tag, ".src"},      cdb_src,    vecs[i].esrc);
      checkOutput({tag, ".aluReady"}, alu_ready,  vecs[i].ear);
      checkOutput({tag, ".lsbReady"}, lsb_ready,  vecs[i].elr);
      @(posedge clk_in);
      @(negedge clk_in);
    end
    doReset("afterTable");
`else
    driveInputs(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'hABCD, 1'b1, 1'b0);
    #1;
    checkOutput("bypass.valid", cdb_valid, 1'b1);
    checkOutput("bypass.src",   cdb_src,   1'b1);
    checkOutput("bypass.id",    cdb_rob_id, 4'd7);
    checkOutput("bypass.value", cdb_value, 32'hABCD);
    @(posedge clk_in);
    @(negedge clk_in);
    driveInputs(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    #1;
    checkOutput("bypass.noStale", cdb_valid, 1'b0);
    checkOutput("bypass.lsbReady", lsb_ready, 1'b1);
    @(negedge clk_in);
    doReset("afterBypass");
`endif

    // Continuous contention: each source holds its offer until accepted
    sawLsbFull = 1'b0;
    aN = 0; lN = 0;
    for (int c = 0; c < 24; c++) begin
      aAccept = aq.size() < DEPTH;
      lAccept = lq.size() < DEPTH;
      applyStimulus("contend", 1'b1, 4'(aN), 32'hA000 + aN, 1'b1, 4'(lN), 32'hB000 + lN, 1'b1, 1'b0);
      if (aAccept) aN++;
      if (lAccept) lN++;
      if (lsb_ready == 1'b0) sawLsbFull = 1'b1;
    end
    checkOutput("contend.lsbFullSeen", sawLsbFull, 1'b1);

    // Drain until exactly three ALU results remain, then flush
    guard = 0;
    while (aq.size() != 3 && guard < 20) begin
      applyStimulus("drain", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
      guard++;
    end
    applyStimulus("flush", 1'b1, 4'd12, 32'hC0C0, 1'b1, 4'd13, 32'hD0D0, 1'b1, 1'b1);
    applyStimulus("postFlush", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("postFlush.aluEmpty", alu_ready, 1'b1);

    // Stall: entries queued, rdy_in low for five cycles, then resume
    applyStimulus("stallFill", 1'b1, 4'd10, 32'h1010, 1'b1, 4'd11, 32'h1111, 1'b1, 1'b0);
    applyStimulus("stallFill", 1'b1, 4'd14, 32'h1414, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    for (int s = 0; s < 5; s++)
      applyStimulus("stall", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++)
      applyStimulus("resume", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);

    // Random traffic against the model
    for (int r = 0; r < 600; r++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                    1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0));
    end

    // Reset mid-operation with results buffered
    for (int s = 0; s < 4; s++)
      applyStimulus("preReset", 1'b1, 4'(s), 32'h7000 + s, 1'b1, 4'(s + 8), 32'h8000 + s, 1'b1, 1'b0);
    doReset("midRun");
    applyStimulus("afterReset", 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
